fpu_f2i: RTL and testbench
==========================

Name: fpu_f2i

Overview:
- Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter.
- It is the decode direction for the fpu adder: it takes a packed float (typically fpu data_out) and returns a two's-complement integer and a 4-bit status.
- It uses one iterative shifter, one bit position per cycle, to keep area small.
- It sits beside fpu on the same clk/reset domain and uses the same op/data/status port style.

Parameters:
- MAX_RSHIFT, 25, clamp on right-shift iterations. Exponents below -2 skip the shifter.
- BIAS, 127, IEEE-754 single exponent bias.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op_A_in  input  32  IEEE-754 single operand; sampled when start_in is accepted
- start_in  input  1  request pulse; accepted only in IDLE
- busy_out  output  1  high from acceptance until done_out
- done_out  output  1  one-cycle pulse; data_out and status_out are valid from this cycle
- data_out  output  32  signed integer result; held until the next done_out
- status_out  output  4  [3] negative result, [2] zero result, [1] invalid, [0] inexact

Behaviour:
- Reset (synchronous, active-high) sets: state IDLE; busy_out=0; done_out=0; data_out=0; status_out=0.
- Reset mid-conversion aborts the conversion immediately and leaves no partial result.

- States: IDLE -> UNPACK -> SHIFT -> ROUND -> DONE -> IDLE.
- IDLE: when start_in=1, latch op_A_in, set busy_out=1, go to UNPACK. start_in in any other state is ignored and not queued.
- UNPACK: compute s, e = exp-BIAS, and mant = {hidden, frac}, with hidden=0 when exp=0. Special cases go straight to ROUND with a forced result:
  - NaN or Inf (exp=255): result 0x7FFFFFFF if s=0 or the value is NaN, else 0x80000000; invalid=1.
  - e>=31: same saturation and invalid=1, except s=1, e=31, frac=0, which is exact 0x80000000.
  - exp=0 (zero/denormal) or e<-2: result 0; inexact = (mant!=0).
  - Otherwise: shift count n = e-23 (left) when e>=23, else min(23-e, MAX_RSHIFT) (right). If n=0, go directly to ROUND.
- SHIFT: one position per cycle, decrement n.
  - Right shift: guard takes the outgoing bit; the previous guard ORs into sticky.
  - Leave SHIFT when n reaches 0.
- ROUND: round-to-nearest-even. Increment when guard & (sticky | lsb). inexact = guard | sticky. Then negate if s=1.
- DONE: register data_out and status_out, pulse done_out, drop busy_out, return to IDLE. start_in is accepted again the next cycle.
- Latency from the acceptance edge to done_out high is n+3 cycles. Special cases take 3 cycles.
- Magnitude never exceeds 2^31 after rounding, because e<=30 paths with rounding are bounded at 2^24.
- Status:
  - zero = (data_out==0).
  - negative = data_out[31].
  - -0.0 gives 0 with status 0100.

Optional Feature:
- Macro: FPU_F2I_RMODE_EN.
- Defined: adds input rmode_in (1 bit), sampled together with op_A_in.
  - rmode_in=0: round-to-nearest-even.
  - rmode_in=1: truncate toward zero. Inexact is still reported.
- Undefined: the port is absent and only round-to-nearest-even exists.

Decomposition:
- fpu_pkg:
  - BIAS
  - EXP_W=8, FRAC_W=23
  - status bit index constants
  - state enum typedef
  - saturation constants INT_MAX/INT_MIN
- Sub-module fpu_rne_round (combinational): mantissa, guard, sticky, mode -> rounded magnitude and inexact. fpu adder paths can reuse it.

Test Plan:
- 0x3F800000 (1.0) -> 0x00000001, status 0000, done_out exactly 26 cycles after acceptance.
- 0x40200000 (2.5) -> 0x00000002, status 0001; 0x40600000 (3.5) -> 0x00000004, status 0001 (ties-to-even).
- 0xC0400000 (-3.0) -> 0xFFFFFFFD, status 1000; 0x80000000 (-0.0) -> 0x00000000, status 0100.
- 0x4F000000 (2^31) -> 0x7FFFFFFF, status 0010; 0xCF000000 (-2^31) -> 0x80000000, status 1000; 0x7FC00000 (NaN) -> 0x7FFFFFFF, status 0010.
- 0x00000001 (min denormal) -> 0x00000000, status 0101 in 3 cycles; a second start_in while busy_out=1 is ignored.
- Reset asserted mid-SHIFT: next cycle busy_out=0 and data_out=0 with no done_out. A new start with 0x40000000 then yields 0x00000002.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the fpu float/int conversion paths.
package fpu_pkg;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam int ST_NEG  = 3;
  localparam int ST_ZERO = 2;
  localparam int ST_INV  = 1;
  localparam int ST_INEX = 0;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } f2i_state_e;
endpackage

// File: rtl/fpu_f2i_if.sv
// Request/result bundle for fpu_f2i; rmode_in exists only with FPU_F2I_RMODE_EN.
interface fpu_f2i_if;
  logic [31:0] op_A_in;
  logic        start_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;
`ifdef FPU_F2I_RMODE_EN
  logic        rmode_in;

  modport master (output op_A_in, start_in, rmode_in,
                  input  busy_out, done_out, data_out, status_out);
  modport slave  (input  op_A_in, start_in, rmode_in,
                  output busy_out, done_out, data_out, status_out);
`else
  modport master (output op_A_in, start_in,
                  input  busy_out, done_out, data_out, status_out);
  modport slave  (input  op_A_in, start_in,
                  output busy_out, done_out, data_out, status_out);
`endif
endinterface

// File: rtl/fpu_rne_round.sv
// Combinational rounding of a shifted magnitude from its guard/sticky bits;
// trunc_i selects round-toward-zero instead of nearest-even.
module fpu_rne_round (
  input  logic [31:0] mag_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        trunc_i,
  output logic [31:0] mag_o,
  output logic        inexact_o
);
  logic up;

  assign inexact_o = guard_i | sticky_i;
  assign up        = ~trunc_i & guard_i & (sticky_i | mag_i[0]);
  assign mag_o     = mag_i + 32'(up);
endmodule

// File: rtl/fpu_f2i.sv
// Iterative float32 -> int32 converter, one shift position per cycle.
// Define FPU_F2I_RMODE_EN to add the rmode_in truncate-toward-zero select.
module fpu_f2i
  import fpu_pkg::*;
#(
  parameter int MAX_RSHIFT = 25,
  parameter int BIAS       = fpu_pkg::BIAS
) (
  input  logic clk,
  input  logic reset,
  fpu_f2i_if.slave bus
);
  localparam int CNT_W = 6;
  localparam logic signed [9:0] MAXR = 10'(MAX_RSHIFT);

  f2i_state_e state_q, state_d;
  logic [31:0]      op_q, op_d;
  logic [31:0]      mag_q, mag_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             left_q, left_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             forced_q, forced_d;
  logic [31:0]      res_q, res_d;
  logic             invalid_q, invalid_d;
  logic             inexact_q, inexact_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       status_q, status_d;
  logic             done_q, done_d;
  logic             rmode_q, rmode_d;

  logic                s;
  logic [EXP_W-1:0]    exp_f;
  logic [FRAC_W-1:0]   frac;
  logic [FRAC_W:0]     mant;
  logic signed [9:0]   e;
  logic signed [9:0]   rsh;
  logic [31:0]         mag_r;
  logic                rnd_inexact;

  assign s     = op_q[31];
  assign exp_f = op_q[30:23];
  assign frac  = op_q[22:0];
  assign mant  = {exp_f != '0, frac};
  assign e     = 10'(exp_f) - 10'(BIAS);
  assign rsh   = 10'sd23 - e;

  fpu_rne_round u_round (
    .mag_i     (mag_q),
    .guard_i   (guard_q),
    .sticky_i  (sticky_q),
    .trunc_i   (rmode_q),
    .mag_o     (mag_r),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mag_d     = mag_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    left_d    = left_q;
    cnt_d     = cnt_q;
    forced_d  = forced_q;
    res_d     = res_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    data_d    = data_q;
    status_d  = status_q;
    done_d    = 1'b0;
    rmode_d   = rmode_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          op_d    = bus.op_A_in;
`ifdef FPU_F2I_RMODE_EN
          rmode_d = bus.rmode_in;
`else
          rmode_d = 1'b0;
`endif
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        forced_d  = 1'b1;
        invalid_d = 1'b0;
        inexact_d = 1'b0;
        guard_d   = 1'b0;
        sticky_d  = 1'b0;
        left_d    = 1'b0;
        cnt_d     = '0;
        mag_d     = '0;
        res_d     = '0;
        state_d   = S_ROUND;
        if (exp_f == '1) begin
          res_d     = (!s || frac != '0) ? INT_MAX : INT_MIN;
          invalid_d = 1'b1;
        end else if (e >= 10'sd31) begin
          // -2^31 is the one representable value in this range
          if (s && e == 10'sd31 && frac == '0) begin
            res_d = INT_MIN;
          end else begin
            res_d     = s ? INT_MIN : INT_MAX;
            invalid_d = 1'b1;
          end
        end else if (exp_f == '0 || e < -10'sd2) begin
          inexact_d = (mant != '0);
        end else begin
          forced_d = 1'b0;
          mag_d    = 32'(mant);
          if (e >= 10'sd23) begin
            left_d = 1'b1;
            cnt_d  = CNT_W'(e - 10'sd23);
          end else begin
            cnt_d  = (rsh > MAXR) ? CNT_W'(MAXR) : CNT_W'(rsh);
          end
          if (cnt_d != '0) state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!forced_q) begin
          res_d     = s ? (~mag_r + 32'd1) : mag_r;
          inexact_d = rnd_inexact;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        data_d           = res_q;
        status_d         = '0;
        status_d[ST_NEG]  = res_q[31];
        status_d[ST_ZERO] = (res_q == '0);
        status_d[ST_INV]  = invalid_q;
        status_d[ST_INEX] = inexact_q;
        done_d           = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      left_q    <= 1'b0;
      cnt_q     <= '0;
      forced_q  <= 1'b0;
      res_q     <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
      data_q    <= '0;
      status_q  <= '0;
      done_q    <= 1'b0;
      rmode_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      left_q    <= left_d;
      cnt_q     <= cnt_d;
      forced_q  <= forced_d;
      res_q     <= res_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
      data_q    <= data_d;
      status_q  <= status_d;
      done_q    <= done_d;
      rmode_q   <= rmode_d;
    end
  end

  assign bus.busy_out   = (state_q != S_IDLE);
  assign bus.done_out   = done_q;
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;
endmodule

// File: tb/tb_fpu_f2i.sv
// Directed-vector bench for fpu_f2i with hand-computed results and latencies.
module tb_fpu_f2i;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fpu_f2i_if bus ();

  fpu_f2i dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one conversion; poke drives a competing start while busy.
  task automatic conv(input string tag, input logic [31:0] op, input logic [31:0] exp_d,
                      input logic [3:0] exp_s, input int exp_lat, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    bus.op_A_in  = op;
    bus.start_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    chk({tag, " busy"}, 32'(bus.busy_out), 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      if (poke && lat == 0) begin
        bus.op_A_in  = 32'h3F80_0000;
        bus.start_in = 1'b1;
      end
      @(posedge clk);
      lat++;
      #1;
      bus.start_in = 1'b0;
      if (bus.done_out) seen = 1'b1;
    end
    chk({tag, " done"}, 32'(seen), 32'd1);
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " data"}, bus.data_out, exp_d);
    chk({tag, " status"}, 32'(bus.status_out), 32'(exp_s));
    chk({tag, " busy_drop"}, 32'(bus.busy_out), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, 32'(bus.done_out), 32'd0);
    chk({tag, " idle"}, 32'(bus.busy_out), 32'd0);
  endtask

  initial begin
    int dones;
    reset        = 1'b1;
    bus.start_in = 1'b0;
    bus.op_A_in  = '0;
`ifdef FPU_F2I_RMODE_EN
    bus.rmode_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.busy_out), 32'd0);
    chk("rst done", 32'(bus.done_out), 32'd0);
    chk("rst data", bus.data_out, 32'd0);
    chk("rst status", 32'(bus.status_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    conv("one",     32'h3F80_0000, 32'h0000_0001, 4'b0000, 26, 1'b0);
    conv("2.5",     32'h4020_0000, 32'h0000_0002, 4'b0001, 25, 1'b0);
    conv("3.5",     32'h4060_0000, 32'h0000_0004, 4'b0001, 25, 1'b0);
    conv("-3.0",    32'hC040_0000, 32'hFFFF_FFFD, 4'b1000, 25, 1'b0);
    conv("-0.0",    32'h8000_0000, 32'h0000_0000, 4'b0100, 3,  1'b0);
    conv("2^31",    32'h4F00_0000, 32'h7FFF_FFFF, 4'b0010, 3,  1'b0);
    conv("-2^31",   32'hCF00_0000, 32'h8000_0000, 4'b1000, 3,  1'b0);
    conv("nan",     32'h7FC0_0000, 32'h7FFF_FFFF, 4'b0010, 3,  1'b0);
    conv("-inf",    32'hFF80_0000, 32'h8000_0000, 4'b1010, 3,  1'b0);
    conv("denorm",  32'h0000_0001, 32'h0000_0000, 4'b0101, 3,  1'b1);
    conv("0.5",     32'h3F00_0000, 32'h0000_0000, 4'b0101, 27, 1'b0);
    conv("0.75",    32'h3F40_0000, 32'h0000_0001, 4'b0001, 27, 1'b0);
    conv("2^23",    32'h4B00_0000, 32'h0080_0000, 4'b0000, 3,  1'b0);
    conv("2^30",    32'h4E80_0000, 32'h4000_0000, 4'b0000, 10, 1'b0);

    // abort mid-SHIFT; data_out was nonzero from the previous conversion
    @(negedge clk);
    bus.op_A_in  = 32'h3F80_0000;
    bus.start_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", 32'(bus.busy_out), 32'd0);
    chk("abort data", bus.data_out, 32'd0);
    chk("abort done", 32'(bus.done_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done_out) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    conv("after abort", 32'h4000_0000, 32'h0000_0002, 4'b0000, 25, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
